wb_bram_ctrl: RTL and testbench

Wishbone classic slave that fronts the user-project BRAM. It decodes Caravel Wishbone cycles aimed at the BRAM window, drives the BRAM port (EN/WE/A/Di), and holds the request until the BRAM's READY pulse. It then returns the read word with a single-cycle ack. The block sits directly upstream of `bram`, between the Wishbone bus and the memory, and hides the BRAM's fixed multi-cycle latency from the CPU.

---
 rtl/wb_bram_pkg.sv | 21 ++
 rtl/wb_bram_ctrl.sv | 117 +++++++++++
 tb/tb_wb_bram_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone-to-BRAM controller: FSM states,
// default geometry and the word returned when the BRAM never answers.
package wb_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0]  BASE_DEF    = 8'h38;
    localparam int          ADDR_W_DEF  = 10;
    localparam int          TIMEOUT_DEF = 32;
    localparam logic [31:0] ERR_WORD    = 32'hFFFF_FFFF;

    // Write lanes presented to the BRAM: nothing unless this is a write.
    function automatic logic [3:0] lane_mask(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave in front of the user-project BRAM: holds each
// request on the BRAM port until READY, then returns a single-cycle ack.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0]  BASE    = BASE_DEF,
    parameter int          TIMEOUT = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_a,
    output logic [31:0] bram_di,
    input  logic [31:0] bram_do,
    input  logic        bram_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [ADDR_W-1:0]   adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                we_q;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                abort;

    logic hit;
    logic in_access;
    logic abort_now;
    logic tmo_hit;
    logic unused_adr;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE);
    assign in_access = (state == ST_ACCESS);
    // A cycle dropped in the very READY cycle counts as an abort too.
    assign abort_now = abort | ~wbs_cyc_i;
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // EN falls in the READY cycle so the BRAM's latency counter stays aligned.
    assign bram_en = in_access & ~bram_ready;
    assign bram_we = bram_en ? lane_mask(we_q, sel_q) : 4'b0000;
    assign bram_a  = {{(32 - ADDR_W){1'b0}}, adr_q};
    assign bram_di = dat_q;

    assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            tmo_cnt   <= '0;
            abort     <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        adr_q   <= wbs_adr_i[ADDR_W+1:2];
                        dat_q   <= wbs_dat_i;
                        sel_q   <= wbs_sel_i;
                        we_q    <= wbs_we_i;
                        tmo_cnt <= '0;
                        abort   <= 1'b0;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!wbs_cyc_i) begin
                        abort <= 1'b1;
                    end
                    if (bram_ready) begin
                        wbs_dat_o <= bram_do;
                        if (abort_now) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_RESP;
                            wbs_ack_o <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        wbs_dat_o <= ERR_WORD;
                        if (abort_now) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_RESP;
                            wbs_ack_o <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: behavioural 12-cycle BRAM, directed vector table,
// hand sequences for abort/timeout/reset, and random traffic against a word-level memory model.
module tb_wb_bram_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_a, bram_di, bram_do;
    logic        bram_ready;

    always #5 CLK = ~CLK;

    wb_bram_ctrl dut (
        .CLK(CLK), .RST(RST),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di),
        .bram_do(bram_do), .bram_ready(bram_ready)
    );

    // BRAM stand-in: READY follows the 12th sampled EN; stub holds READY low.
    logic [31:0] bram_mem [0:1023];
    int          bram_cnt;
    logic        stub;

    always @(posedge CLK) begin
        if (RST || stub) begin
            bram_cnt   <= 0;
            bram_ready <= 1'b0;
        end else begin
            bram_ready <= 1'b0;
            if (bram_en) begin
                for (int i = 0; i < 4; i++)
                    if (bram_we[i]) bram_mem[bram_a[9:0]][8*i +: 8] <= bram_di[8*i +: 8];
                if (bram_cnt == 11) begin
                    bram_cnt   <= 0;
                    bram_ready <= 1'b1;
                    bram_do    <= bram_mem[bram_a[9:0]];
                end else begin
                    bram_cnt <= bram_cnt + 1;
                end
            end
        end
    end

    // Protocol watchers: back-to-back ack, or write lanes without EN.
    int   viol = 0;
    logic ack_prev = 1'b0;
    always @(negedge CLK) begin
        if (wbs_ack_o && ack_prev) viol <= viol + 1;
        if (bram_we != 4'b0 && !bram_en) viol <= viol + 1;
        ack_prev <= wbs_ack_o;
    end

    logic [31:0] ref_mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        for (int i = 0; i < 4; i++)
            if (sel[i]) ref_mem[adr[11:2]][8*i +: 8] = dat[8*i +: 8];
    endfunction

    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, output logic acked, output logic [31:0] rdata,
                           output int lat, output logic [31:0] a0, output logic [3:0] we0);
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        acked = 1'b0; rdata = '0; lat = -1; a0 = '0; we0 = '0;
        for (int e = 0; e < 60; e++) begin
            @(posedge CLK); #1;
            if (e == 0) begin a0 = bram_a; we0 = bram_we; end
            if (wbs_ack_o) begin acked = 1'b1; rdata = wbs_dat_o; lat = e; break; end
        end
        @(negedge CLK);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_a;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t vecs [5];

    logic        acked;
    logic [31:0] rdata, a0;
    logic [3:0]  we0;
    int          lat, en_cnt, ack_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
        stub = 1'b0; bram_do = '0;
        RST = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;

        vecs[0] = '{1'b1, 4'hF, 32'h3800_0010, 32'h1234_5678, 1'b0, 32'h0,          32'd4, 4'hF};
        vecs[1] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'h1234_5678, 32'd4, 4'h0};
        vecs[2] = '{1'b1, 4'hF, 32'h3800_0020, 32'h1111_1111, 1'b0, 32'h0,          32'd8, 4'hF};
        vecs[3] = '{1'b1, 4'h5, 32'h3800_0020, 32'hAABB_CCDD, 1'b0, 32'h0,          32'd8, 4'h5};
        vecs[4] = '{1'b0, 4'h0, 32'h3800_0020, 32'h0,         1'b1, 32'h11BB_11DD, 32'd8, 4'h0};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_en",  {31'b0, bram_en}, 32'h0);
        check("rst_a",   bram_a, 32'h0);
        @(negedge CLK); RST = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].dat, acked, rdata, lat, a0, we0);
            if (vecs[v].we) ref_write(vecs[v].adr, vecs[v].sel, vecs[v].dat);
            check($sformatf("vec%0d_ack", v), {31'b0, acked}, 32'h1);
            check($sformatf("vec%0d_lat", v), lat, 32'd13);
            check($sformatf("vec%0d_a", v), a0, vecs[v].exp_a);
            check($sformatf("vec%0d_we", v), {28'b0, we0}, {28'b0, vecs[v].exp_we});
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rd", v), rdata, vecs[v].exp_rd);
        end

        // Address outside the window must be ignored entirely.
        @(negedge CLK);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'hDEAD_BEEF;
        en_cnt = 0; ack_cnt = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (bram_en) en_cnt++;
            if (wbs_ack_o) ack_cnt++;
        end
        check("miss_en", en_cnt, 0);
        check("miss_ack", ack_cnt, 0);
        @(negedge CLK); wbs_cyc_i = 0; wbs_stb_i = 0;

        // Master abandons a write after five cycles; the write still lands.
        @(negedge CLK);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0100; wbs_dat_i = 32'hCAFE_F00D;
        repeat (5) @(posedge CLK);
        @(negedge CLK); wbs_cyc_i = 0; wbs_stb_i = 0;
        ack_cnt = 0;
        repeat (25) begin
            @(posedge CLK); #1;
            if (wbs_ack_o) ack_cnt++;
        end
        check("abort_ack", ack_cnt, 0);
        check("abort_en_idle", {31'b0, bram_en}, 32'h0);
        ref_write(32'h3800_0100, 4'hF, 32'hCAFE_F00D);
        run_txn(1'b0, 4'hF, 32'h3800_0100, 32'h0, acked, rdata, lat, a0, we0);
        check("abort_rd", rdata, 32'hCAFE_F00D);
        check("abort_rd_lat", lat, 32'd13);

        // BRAM never answers: error word after the timeout.
        stub = 1'b1;
        run_txn(1'b0, 4'hF, 32'h3800_0010, 32'h0, acked, rdata, lat, a0, we0);
        check("tmo_ack", {31'b0, acked}, 32'h1);
        check("tmo_lat", lat, 32'd32);
        check("tmo_dat", rdata, 32'hFFFF_FFFF);
        stub = 1'b0;

        // Reset during the sixth ACCESS cycle.
        @(negedge CLK);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0010; wbs_dat_i = 32'h0;
        repeat (6) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        check("mrst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("mrst_dat", wbs_dat_o, 32'h0);
        check("mrst_en",  {31'b0, bram_en}, 32'h0);
        check("mrst_we",  {28'b0, bram_we}, 32'h0);
        check("mrst_a",   bram_a, 32'h0);
        check("mrst_di",  bram_di, 32'h0);
        @(negedge CLK); RST = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0;
        run_txn(1'b0, 4'hF, 32'h3800_0010, 32'h0, acked, rdata, lat, a0, we0);
        check("mrst_rd", rdata, 32'h1234_5678);
        check("mrst_lat", lat, 32'd13);

        // Random traffic over a small word range, with junk in the ignored address bits.
        for (int t = 0; t < 40; t++) begin
            logic        rwe;
            logic [3:0]  rsel;
            logic [31:0] rdat, radr;
            logic [9:0]  w;
            rwe  = 1'($urandom);
            rsel = 4'($urandom);
            rdat = $urandom;
            w    = 10'($urandom_range(0, 15));
            radr = {8'h38, 12'($urandom), w, 2'($urandom)};
            run_txn(rwe, rsel, radr, rdat, acked, rdata, lat, a0, we0);
            check($sformatf("rnd%0d_lat", t), lat, 32'd13);
            if (rwe) ref_write(radr, rsel, rdat);
            else     check($sformatf("rnd%0d_rd", t), rdata, ref_mem[w]);
        end

        repeat (2) @(posedge CLK);
        check("protocol_viol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
